nes_reader: RTL and testbench

NES_READER -- requirements
Module: nes_reader

---
 rtl/nes_pkg.sv | 23 ++
 rtl/nes_tick_gen.sv | 24 ++
 rtl/nes_reader.sv | 159 +++++++++++++++
 tb/tb_nes_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    DONE
  } nes_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int LATCH_TICKS = 2;

endpackage

// File: rtl/nes_tick_gen.sv
// Protocol tick generator: one-clk enable every TICK_DIV clk cycles.
module nes_tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nes_reader.sv
// NES controller serial reader: latch, clock out 8 bits, publish active-high buttons.
// Optional NES_READER_DEBOUNCE_EN: publish only when two consecutive frames agree.
//
// state    | meaning
// IDLE     | wait POLL_TICKS ticks between frames
// LATCH    | latch strobe high for LATCH_TICKS ticks, sample bit 0 at the end
// PULSE_HI | shift clock high one tick, sample bit[idx] at the end
// PULSE_LO | shift clock low one tick, advance idx or finish
// DONE     | one clk: publish frame and strobe valid
module nes_reader
  import nes_pkg::*;
#(
  parameter int TICK_DIV   = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int IW = $clog2(POLL_TICKS + 1);

  logic          tick;
  logic          sync1_q, sync2_q;
  nes_state_e    state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          valid_q, valid_d;
  logic          latch_q, latch_d;
  logic          pulse_q, pulse_d;
`ifdef NES_READER_DEBOUNCE_EN
  logic [7:0]    prev_q, prev_d;
`endif

  nes_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    valid_d    = 1'b0;
`ifdef NES_READER_DEBOUNCE_EN
    prev_d     = prev_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (idle_cnt_q == IW'(POLL_TICKS - 1)) begin
            idle_cnt_d = '0;
            state_d    = LATCH;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
      end
      LATCH: begin
        if (tick) begin
          if (lat_cnt_q == 2'(LATCH_TICKS - 1)) begin
            lat_cnt_d        = '0;
            shift_d[BTN_A]   = ~sync2_q;
            idx_d            = 3'd1;
            state_d          = PULSE_HI;
          end else begin
            lat_cnt_d = lat_cnt_q + 2'd1;
          end
        end
      end
      PULSE_HI: begin
        if (tick) begin
          shift_d[idx_q] = ~sync2_q;
          state_d        = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = PULSE_HI;
          end
        end
      end
      DONE: begin
`ifdef NES_READER_DEBOUNCE_EN
        if (shift_q == prev_q) begin
          buttons_d = shift_q;
          valid_d   = 1'b1;
        end
        prev_d = shift_q;
`else
        buttons_d = shift_q;
        valid_d   = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they leave a flop cleanly.
    latch_d = (state_d == LATCH);
    pulse_d = (state_d == PULSE_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      lat_cnt_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      valid_q    <= 1'b0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
`ifdef NES_READER_DEBOUNCE_EN
      prev_q     <= '0;
`endif
    end else begin
      sync1_q    <= nes_data;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      valid_q    <= valid_d;
      latch_q    <= latch_d;
      pulse_q    <= pulse_d;
`ifdef NES_READER_DEBOUNCE_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign nes_latch = latch_q;
  assign nes_pulse = pulse_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_nes_reader.sv
// Directed bench for nes_reader with a behavioural shift-register controller model.
module tb_nes_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_pulse, valid;
  logic [7:0] buttons;

  int total = 0;
  int bad = 0;

  logic [7:0] ctl_mask = 8'h00;
  logic [7:0] ctl_sr = 8'hFF;
  logic       ctl_pulse_prev = 1'b0;

  always #5 clk = ~clk;

  // Controller model: parallel load while latched, shift toward bit 0 on each pulse rise.
  assign nes_data = ctl_sr[0];
  always @(posedge clk) begin
    ctl_pulse_prev <= nes_pulse;
    if (nes_latch) ctl_sr <= ~ctl_mask;
    else if (nes_pulse && !ctl_pulse_prev) ctl_sr <= {1'b1, ctl_sr[7:1]};
  end

  nes_reader #(
    .TICK_DIV(4),
    .POLL_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
    .buttons  (buttons),
    .valid    (valid)
  );

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  task automatic observe_frame(input logic [7:0] mask, output int latch_len, output int rises,
                               output int bad_len, output int overlap, output int vcnt,
                               output logic [7:0] vbtn, output int unstable, output bit timeout);
    int n, run, falls, after;
    bit prevp;
    logic [7:0] last_btn;
    ctl_mask = mask;
    latch_len = 0; rises = 0; bad_len = 0; overlap = 0; vcnt = 0; unstable = 0;
    vbtn = 8'h00; timeout = 1'b0;
    n = 0; run = 0; falls = 0; after = 0; prevp = 1'b0;
    last_btn = buttons;
    while (!nes_latch && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!nes_latch) begin
      timeout = 1'b1;
      return;
    end
    while (after < 10 && n < 400) begin
      if (nes_latch) latch_len++;
      if (nes_latch && nes_pulse) overlap++;
      if (nes_pulse) begin
        if (!prevp) rises++;
        run++;
      end else if (prevp) begin
        if (run != 4) bad_len++;
        run = 0;
        falls++;
      end
      if (valid) begin
        vcnt++;
        vbtn = buttons;
      end else if (buttons !== last_btn) begin
        unstable++;
      end
      last_btn = buttons;
      prevp = nes_pulse;
      if (falls >= 7) after++;
      @(posedge clk); #1; n++;
    end
    if (after < 10) timeout = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (nes_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b want=0", nes_latch); end
    total++; if (nes_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", nes_pulse); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (buttons !== 8'h00) begin bad++; $display("FAIL reset_buttons got=%h want=00", buttons); end
  endtask

  task automatic test_reset_release();
    int n, m, nz;
    bit seen;
    ctl_mask = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0; nz = 0;
    while (!nes_latch && n < 100) begin
      @(posedge clk); #1; n++;
      if (buttons !== 8'h00) nz++;
    end
    total++; if (n != 12) begin bad++; $display("FAIL release_latch_delay got=%0d want=12", n); end
    m = 0;
    while (nes_latch && m < 100) begin
      @(posedge clk); #1; m++;
      if (buttons !== 8'h00) nz++;
    end
    total++; if (m != 8) begin bad++; $display("FAIL release_latch_len got=%0d want=8", m); end
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      if (valid) seen = 1'b1;
      else begin
        @(posedge clk); #1; n++;
        if (buttons !== 8'h00) nz++;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL release_valid got=none want=strobe"); end
    total++; if (nz != 0) begin bad++; $display("FAIL release_buttons_zero got=%0d nonzero cycles want=0", nz); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_frame(input string name, input logic [7:0] mask, input logic [7:0] expected);
    int ll, rs, bl, ov, vc, us;
    logic [7:0] vb;
    bit to;
    observe_frame(mask, ll, rs, bl, ov, vc, vb, us, to);
    total++; if (to) begin bad++; $display("FAIL %s timeout got=1 want=0", name); end
    total++; if (ll != 8) begin bad++; $display("FAIL %s latch_len got=%0d want=8", name, ll); end
    total++; if (rs != 7) begin bad++; $display("FAIL %s pulse_rises got=%0d want=7", name, rs); end
    total++; if (bl != 0) begin bad++; $display("FAIL %s pulse_width_errs got=%0d want=0", name, bl); end
    total++; if (ov != 0) begin bad++; $display("FAIL %s latch_pulse_overlap got=%0d want=0", name, ov); end
    total++; if (vc != 1) begin bad++; $display("FAIL %s valid_cycles got=%0d want=1", name, vc); end
    total++; if (vb !== expected) begin bad++; $display("FAIL %s buttons got=%h want=%h", name, vb, expected); end
    total++; if (us != 0) begin bad++; $display("FAIL %s buttons_unstable got=%0d want=0", name, us); end
  endtask

  task automatic test_mid_reset();
    int n, r, nz;
    bit p, seen;
    ctl_mask = 8'hA5;
    n = 0;
    while (!nes_latch && n < 200) begin
      @(posedge clk); #1; n++;
    end
    r = 0; p = nes_pulse; n = 0;
    while (r < 4 && n < 300) begin
      @(posedge clk); #1; n++;
      if (nes_pulse && !p) r++;
      p = nes_pulse;
    end
    total++; if (r != 4) begin bad++; $display("FAIL midrst_find_pulse got=%0d want=4", r); end
    #3;
    reset = 1'b0;
    #1;
    total++; if (nes_pulse !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%b want=0", nes_pulse); end
    total++; if (nes_latch !== 1'b0) begin bad++; $display("FAIL midrst_latch got=%b want=0", nes_latch); end
    total++; if (buttons !== 8'h00) begin bad++; $display("FAIL midrst_buttons got=%h want=00", buttons); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", valid); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0; nz = 0;
    while (!nes_latch && n < 100) begin
      @(posedge clk); #1; n++;
      if (buttons !== 8'h00) nz++;
    end
    total++; if (n != 12) begin bad++; $display("FAIL midrst_latch_delay got=%0d want=12", n); end
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      if (valid) seen = 1'b1;
      else begin
        if (buttons !== 8'h00) nz++;
        @(posedge clk); #1; n++;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_valid_after got=none want=strobe"); end
    total++; if (nz != 0) begin bad++; $display("FAIL midrst_buttons_hold got=%0d nonzero cycles want=0", nz); end
    total++; if (buttons !== 8'hA5) begin bad++; $display("FAIL midrst_next_frame got=%h want=a5", buttons); end
    repeat (3) @(posedge clk);
    #1;
  endtask

`ifdef NES_READER_DEBOUNCE_EN
  task automatic test_debounce();
    int ll, rs, bl, ov, vc, us;
    logic [7:0] vb;
    bit to;
    observe_frame(8'h01, ll, rs, bl, ov, vc, vb, us, to);
    total++; if (vc != 0 || to) begin bad++; $display("FAIL deb_frame1_valid got=%0d want=0", vc); end
    total++; if (buttons !== 8'h00) begin bad++; $display("FAIL deb_frame1_buttons got=%h want=00", buttons); end
    observe_frame(8'h01, ll, rs, bl, ov, vc, vb, us, to);
    total++; if (vc != 1 || to) begin bad++; $display("FAIL deb_frame2_valid got=%0d want=1", vc); end
    total++; if (vb !== 8'h01) begin bad++; $display("FAIL deb_frame2_buttons got=%h want=01", vb); end
    observe_frame(8'h80, ll, rs, bl, ov, vc, vb, us, to);
    total++; if (vc != 0 || to) begin bad++; $display("FAIL deb_frame3_valid got=%0d want=0", vc); end
    total++; if (buttons !== 8'h01) begin bad++; $display("FAIL deb_frame3_buttons got=%h want=01", buttons); end
    total++; if (us != 0) begin bad++; $display("FAIL deb_frame3_unstable got=%0d want=0", us); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_release();
`ifdef NES_READER_DEBOUNCE_EN
    test_debounce();
`else
    test_frame("a_start", 8'h09, 8'h09);
    test_frame("none", 8'h00, 8'h00);
    test_frame("all", 8'hFF, 8'hFF);
    test_frame("right_only", 8'h80, 8'h80);
    test_frame("mixed", 8'h5A, 8'h5A);
    test_mid_reset();
    test_frame("after_reset", 8'h3C, 8'h3C);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
